mem_io_responder: RTL and testbench

//  Responder end of the CPU byte bus (mem_a/mem_dout/mem_din/mem_wr): owns the RAM and the I/O window.

---
 rtl/mem_io_responder_pkg.sv | 33 +++
 rtl/mem_io_responder_if.sv | 27 ++
 rtl/mem_io_responder_byte_fifo.sv | 57 +++++
 rtl/mem_io_responder.sv | 159 +++++++++++++++
 tb/tb_mem_io_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared types, I/O window addresses and bus-cycle decode for the CPU byte-bus responder.
package memio_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [17:0] io_addr_t;

    localparam io_addr_t   IO_IN_ADDR  = 18'h30000;
    localparam io_addr_t   IO_CLK_ADDR = 18'h30004;
    localparam logic [1:0] IO_SEL      = 2'b11;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_RAM_RD,
        OP_RAM_WR,
        OP_RX_POP,
        OP_TX_PUSH,
        OP_CLK_RD,
        OP_STOP,
        OP_ZERO_RD
    } bus_op_e;

    function automatic bus_op_e decode_op(input io_addr_t a, input logic wr);
        if (a[17:16] != IO_SEL) return wr ? OP_RAM_WR : OP_RAM_RD;
        if (a == IO_IN_ADDR)    return wr ? OP_TX_PUSH : OP_RX_POP;
        if (a[17:2] == IO_CLK_ADDR[17:2]) begin
            if (!wr)              return OP_CLK_RD;
            if (a[1:0] == 2'b00)  return OP_STOP;
            return OP_NONE;
        end
        return wr ? OP_NONE : OP_ZERO_RD;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus host rx/tx byte streams; slave = responder side, master = cpu/host side.
interface mem_io_if;
    import memio_pkg::*;

    logic [31:0] mem_a;
    byte_t       mem_dout;
    logic        mem_wr;
    byte_t       mem_din;
    logic        rdy_out;
    logic        rx_valid;
    byte_t       rx_data;
    logic        rx_ready;
    logic        tx_valid;
    byte_t       tx_data;
    logic        tx_ready;

    modport slave (
        input  mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        output mem_din, rdy_out, rx_ready, tx_valid, tx_data
    );

    modport master (
        output mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        input  mem_din, rdy_out, rx_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// First-word-fall-through byte FIFO; DEPTH must be a power of 2. Pushes to a full FIFO are
// dropped unless a pop happens on the same edge.
module byte_fifo
    import memio_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        push,
    input  byte_t       push_data,
    input  logic        pop,
    output byte_t       head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count_nxt
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head      = mem_q[rd_ptr_q];
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count_nxt = count_d;

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: RAM, rx/tx byte FIFOs, cycle counter and program-stop flag.
// Optional MEMIO_BOUNDS_CHECK_EN adds a sticky bus_err output for out-of-range RAM accesses.
module mem_io_responder
    import memio_pkg::*;
#(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_io_if.slave      bus,
    output logic         prog_stop
`ifdef MEMIO_BOUNDS_CHECK_EN
    ,
    output logic         bus_err
`endif
);

    localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;
    localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;

    byte_t             ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    bus_op_e           op;

    byte_t       mem_din_q, mem_din_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        stop_q, stop_d;
    logic        rdy_q, rdy_d;

    logic           rx_pop, rx_full, rx_empty;
    byte_t          rx_head;
    logic [RCW-1:0] rx_cnt_unused;
    logic           tx_push, tx_full, tx_empty;
    byte_t          tx_push_data, tx_head;
    logic [TCW-1:0] tx_cnt_nxt;

`ifdef MEMIO_BOUNDS_CHECK_EN
    logic err_q, err_d;
    logic in_range;
`endif

    assign ram_idx = bus.mem_a[RAM_AW-1:0];

    // Bus cycles are ignored while rdy_out is low; out-of-range RAM accesses become zero reads / no-ops.
    always_comb begin
        op = OP_NONE;
        if (rdy_q) op = decode_op(bus.mem_a[17:0], bus.mem_wr);
`ifdef MEMIO_BOUNDS_CHECK_EN
        in_range = ((bus.mem_a[17:0] >> RAM_AW) == '0) && (bus.mem_a[31:18] == '0);
        err_d    = err_q;
        if ((op == OP_RAM_RD || op == OP_RAM_WR) && !in_range) begin
            err_d = 1'b1;
            op    = (op == OP_RAM_RD) ? OP_ZERO_RD : OP_NONE;
        end
`endif
    end

    always_comb begin
        mem_din_d    = mem_din_q;
        snap_d       = snap_q;
        stop_d       = stop_q;
        cnt_d        = cnt_q + 32'd1;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = bus.mem_dout;
        case (op)
            OP_RAM_RD:  mem_din_d = ram[ram_idx];
            OP_RX_POP: begin
                mem_din_d = rx_empty ? '0 : rx_head;
                rx_pop    = !rx_empty;
            end
            OP_TX_PUSH: tx_push = (bus.mem_dout != '0);
            OP_CLK_RD: begin
                case (bus.mem_a[1:0])
                    2'd0: begin
                        snap_d    = cnt_q;
                        mem_din_d = cnt_q[7:0];
                    end
                    2'd1:    mem_din_d = snap_q[15:8];
                    2'd2:    mem_din_d = snap_q[23:16];
                    default: mem_din_d = snap_q[31:24];
                endcase
            end
            OP_STOP: begin
                stop_d       = 1'b1;
                tx_push      = 1'b1;
                tx_push_data = '0;
            end
            OP_ZERO_RD: mem_din_d = '0;
            default: ;
        endcase
        // Based on next occupancy so a write landing as rdy falls still finds a free slot.
        rdy_d = (tx_cnt_nxt <= TCW'(TX_DEPTH - 2));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            stop_q    <= 1'b0;
            rdy_q     <= 1'b1;
`ifdef MEMIO_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            mem_din_q <= mem_din_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            stop_q    <= stop_d;
            rdy_q     <= rdy_d;
`ifdef MEMIO_BOUNDS_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (op == OP_RAM_WR) ram[ram_idx] <= bus.mem_dout;
    end

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (bus.rx_valid && !rx_full),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count_nxt (rx_cnt_unused)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (!tx_empty && bus.tx_ready),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count_nxt (tx_cnt_nxt)
    );

    assign bus.mem_din  = mem_din_q;
    assign bus.rdy_out  = rdy_q;
    assign bus.rx_ready = !rx_full;
    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_head;
    assign prog_stop    = stop_q;
`ifdef MEMIO_BOUNDS_CHECK_EN
    assign bus_err      = err_q;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed plus randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic prog_stop;
`ifdef MEMIO_BOUNDS_CHECK_EN
    logic bus_err;
`endif

    mem_io_if bus ();

    mem_io_responder #(.RAM_AW(17), .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .bus       (bus),
        .prog_stop (prog_stop)
`ifdef MEMIO_BOUNDS_CHECK_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mram [int unsigned];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [7:0]  seen [$];
    int unsigned addrs [$];
    int unsigned cnt_m, snap_m;
    logic [7:0]  din_m;
    bit          stop_m, rdy_m, err_m;
    int          vecs = 0;
    int          errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        cnt_m  = 0;
        snap_m = 0;
        din_m  = 8'h00;
        stop_m = 1'b0;
        rdy_m  = 1'b1;
        err_m  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("mem_din",   bus.mem_din,  din_m);
        chk("rdy_out",   bus.rdy_out,  rdy_m);
        chk("tx_valid",  bus.tx_valid, txq.size() != 0);
        chk("rx_ready",  bus.rx_ready, rxq.size() < DEPTH);
        chk("prog_stop", prog_stop,    stop_m);
`ifdef MEMIO_BOUNDS_CHECK_EN
        chk("bus_err",   bus_err,      err_m);
`endif
    endtask

    task automatic tx_model_push(input logic [7:0] b);
        if (txq.size() < DEPTH) txq.push_back(b);
    endtask

    // Apply one clock edge: update the model from the inputs currently driven, then check.
    task automatic tick();
        logic [31:0] a;
        logic [17:0] a18;
        logic [7:0]  d;
        logic        wr;
        int unsigned rx_sz, k, idx;
        a     = bus.mem_a;
        a18   = a[17:0];
        wr    = bus.mem_wr;
        d     = bus.mem_dout;
        rx_sz = rxq.size();
        if (bus.tx_valid && bus.tx_ready) seen.push_back(bus.tx_data);
        if (bus.tx_ready && txq.size() != 0) begin
            chk("tx_valid_pre", bus.tx_valid, 1'b1);
            chk("tx_data", bus.tx_data, txq[0]);
            void'(txq.pop_front());
        end
        if (rdy_m) begin
            if ((a18 >> 16) != 3) begin
`ifdef MEMIO_BOUNDS_CHECK_EN
                if ((a >> 17) != 0) begin
                    err_m = 1'b1;
                    if (!wr) din_m = 8'h00;
                end else
`endif
                begin
                    idx = a % (1 << 17);
                    if (wr) begin
                        mram[idx] = d;
                        addrs.push_back(a);
                    end else begin
                        din_m = mram.exists(idx) ? mram[idx] : 8'h00;
                    end
                end
            end else if (a18 == 18'h30000) begin
                if (wr) begin
                    if (d != 8'h00) tx_model_push(d);
                end else begin
                    din_m = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
                end
            end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
                k = a18 - 18'h30004;
                if (wr) begin
                    if (k == 0) begin
                        stop_m = 1'b1;
                        tx_model_push(8'h00);
                    end
                end else if (k == 0) begin
                    snap_m = cnt_m;
                    din_m  = 8'(cnt_m);
                end else begin
                    din_m  = 8'(snap_m >> (8 * k));
                end
            end else if (!wr) begin
                din_m = 8'h00;
            end
        end
        if (bus.rx_valid && rx_sz < DEPTH) rxq.push_back(bus.rx_data);
        cnt_m++;
        rdy_m = (txq.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
    endtask

    initial begin
        int unsigned base, guard, sel, lo;
        logic [31:0] ra;
        logic [7:0]  rd;

        drive(32'h0, 1'b1, 8'h00);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b1;
        model_reset();
        check_outputs();

        // Initialise RAM[0] so the idle cycle (read @0) is well defined
        tick();

        // RAM write then read: data visible one cycle after the read address
        drive(32'h00100, 1'b1, 8'hA5);
        tick();
        chk("wr_no_din_change", bus.mem_din, 8'h00);
        drive(32'h00100, 1'b0, 8'h00);
        tick();
        chk("ram_rd_a5", bus.mem_din, 8'hA5);
        drive(32'h00200, 1'b1, 8'h3C);
        tick();
        chk("din_hold", bus.mem_din, 8'hA5);
        drive(32'h00200, 1'b0, 8'h00);
        tick();
        chk("raw_next_cycle", bus.mem_din, 8'h3C);

        // Host rx bytes then three reads of the input port
        drive(32'h0, 1'b0, 8'h00);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        tick();
        bus.rx_data  = 8'h42;
        tick();
        bus.rx_valid = 1'b0;
        drive(32'h30000, 1'b0, 8'h00);
        tick();
        chk("rx_rd0", bus.mem_din, 8'h41);
        tick();
        chk("rx_rd1", bus.mem_din, 8'h42);
        tick();
        chk("rx_rd_empty", bus.mem_din, 8'h00);

        // Output port with zero filter
        bus.tx_ready = 1'b1;
        base = seen.size();
        drive(32'h30000, 1'b1, 8'h48);
        tick();
        drive(32'h30000, 1'b1, 8'h00);
        tick();
        drive(32'h30000, 1'b1, 8'h49);
        tick();
        drive(32'h0, 1'b0, 8'h00);
        repeat (4) tick();
        chk("tx_filtered_cnt", seen.size() - base, 2);
        if (seen.size() >= base + 2) begin
            chk("tx_byte0", seen[base], 8'h48);
            chk("tx_byte1", seen[base + 1], 8'h49);
        end

        // Back-pressure: 15 bytes with host stalled
        bus.tx_ready = 1'b0;
        base = seen.size();
        for (int i = 0; i < 15; i++) begin
            drive(32'h30000, 1'b1, 8'(8'h60 + i));
            tick();
        end
        chk("rdy_low_at_15", bus.rdy_out, 1'b0);
        drive(32'h30000, 1'b1, 8'h77);
        repeat (3) tick();
        bus.tx_ready = 1'b1;
        drive(32'h0, 1'b0, 8'h00);
        guard = 0;
        while (bus.tx_valid && guard < 40) begin
            tick();
            guard++;
        end
        chk("tx_drained", bus.tx_valid, 1'b0);
        chk("rdy_high_again", bus.rdy_out, 1'b1);
        chk("tx_none_lost", seen.size() - base, 15);
        for (int i = 0; i < 15; i++)
            if (base + i < seen.size()) chk("tx_order", seen[base + i], 8'(8'h60 + i));

        // Cycle counter snapshot at cycle 1000
        guard = 0;
        while (cnt_m < 1000 && guard < 2000) begin
            tick();
            guard++;
        end
        drive(32'h30004, 1'b0, 8'h00);
        tick();
        chk("clk_b0", bus.mem_din, 8'hE8);
        for (int k = 1; k < 4; k++) begin
            drive(32'h0, 1'b0, 8'h00);
            repeat (3) tick();
            drive(32'h30004 + k, 1'b0, 8'h00);
            tick();
            chk("clk_snap_byte", bus.mem_din, (k == 1) ? 8'h03 : 8'h00);
        end
        drive(32'h30004, 1'b1, 8'h5A);
        tick();
        chk("prog_stop_set", prog_stop, 1'b1);
        drive(32'h0, 1'b0, 8'h00);
        base = seen.size();
        repeat (2) tick();
        chk("stop_tx_cnt", seen.size() - base, 1);
        if (seen.size() > base) chk("stop_tx_zero", seen[base], 8'h00);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            bus.rx_valid = ($urandom_range(0, 2) == 0);
            bus.rx_data  = 8'($urandom);
            sel = $urandom_range(0, 9);
            rd  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            case (sel)
                0, 1: begin
                    lo = $urandom_range(0, 32'h1FFFF);
                    ra = lo;
                    if ($urandom_range(0, 3) == 0) begin
                        ra = ra | ($urandom & 32'hFFFC0000);
                        if (lo < 32'h10000) ra = ra | 32'h20000;
                    end
                    drive(ra, 1'b1, rd);
                end
                2, 3: drive(addrs[$urandom_range(0, addrs.size() - 1)], 1'b0, 8'h00);
                4: drive(32'h30000, 1'b0, 8'h00);
                5: drive(32'h30000, 1'b1, rd);
                6: drive(32'h30004 + $urandom_range(0, 3), 1'b0, 8'h00);
                7: drive(32'h30000 | $urandom_range(8, 16'hFFFF) | ($urandom & 32'hFFFC0000),
                         1'($urandom), rd);
                8: drive(($urandom_range(0, 7) == 0) ? 32'h30004 : 32'h30005 + $urandom_range(0, 2),
                         1'b1, rd);
                default: drive(32'h0, 1'b0, 8'h00);
            endcase
            tick();
        end

        // Asynchronous reset with both FIFOs holding data
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        drive(32'h30000, 1'b1, 8'h55);
        repeat (3) tick();
        #2;
        rst_in = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        drive(32'h30000, 1'b0, 8'h00);
        tick();
        chk("rx_empty_after_rst", bus.mem_din, 8'h00);
        chk("tx_empty_after_rst", bus.tx_valid, 1'b0);
        drive(32'h0, 1'b0, 8'h00);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
